// File: rtl/vga_overlay_pkg.sv
// Shared timing defaults, segment indices and colour type
// for the VGA 7-segment overlay.
package vga_overlay_pkg;

  localparam logic [9:0] H_TOTAL_D  = 10'd800;
  localparam logic [9:0] H_BACK_D   = 10'd48;
  localparam logic [9:0] H_ACTIVE_D = 10'd640;
  localparam logic [9:0] V_TOTAL_D  = 10'd525;
  localparam logic [9:0] V_BACK_D   = 10'd33;
  localparam logic [9:0] V_ACTIVE_D = 10'd480;
  localparam logic [9:0] ORIGIN_X_D = 10'd256;
  localparam logic [9:0] ORIGIN_Y_D = 10'd120;

  localparam int SEG_LEN_D = 96;
  localparam int SEG_W_D   = 16;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [2:0] color_t;

  localparam color_t FG_RED_D = 3'd7;
  localparam color_t FG_GRN_D = 3'd0;
  localparam color_t FG_BLU_D = 3'd0;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_e;

  // Half-open range test: lo <= v < hi
  function automatic logic in_rng(
    input int v,
    input int lo,
    input int hi
  );
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_segment_overlay_if.sv
// VGA video bundle: active-low syncs plus 3-bit RGB.
// master drives the bundle, slave receives it.
interface vga_segment_overlay_if;
  import vga_overlay_pkg::*;

  logic   hsync;
  logic   vsync;
  color_t red;
  color_t grn;
  color_t blu;

  modport master (
    output hsync, vsync,
    output red, grn, blu
  );

  modport slave (
    input hsync, vsync,
    input red, grn, blu
  );

endinterface

// File: rtl/glyph_segment_hit.sv
// Combinational glyph lookup: signed box-relative rx/ry in,
// 7-bit segment hit vector out (bit0=A .. bit6=G).
module glyph_segment_hit
  import vga_overlay_pkg::*;
#(
  parameter int SEG_LEN = SEG_LEN_D,
  parameter int SEG_W   = SEG_W_D
) (
  input  logic signed [10:0] rx_i,
  input  logic signed [10:0] ry_i,
  output logic        [6:0]  hit_o
);

  localparam int X1 = SEG_W;
  localparam int X2 = SEG_W + SEG_LEN;
  localparam int X3 = SEG_LEN + 2 * SEG_W;
  localparam int Y1 = SEG_W;
  localparam int Y2 = SEG_W + SEG_LEN;
  localparam int Y3 = SEG_LEN + 2 * SEG_W;
  localparam int Y4 = 2 * SEG_LEN + 2 * SEG_W;
  localparam int Y5 = 2 * SEG_LEN + 3 * SEG_W;

  int   rx, ry;
  logic xl, xm, xr;
  logic ya, yu, yg, yl, yd;

  // Sign-extended compares keep negative offsets outside the box
  always_comb begin
    rx = 32'(rx_i);
    ry = 32'(ry_i);
    xl = in_rng(rx, 0, X1);
    xm = in_rng(rx, X1, X2);
    xr = in_rng(rx, X2, X3);
    ya = in_rng(ry, 0, Y1);
    yu = in_rng(ry, Y1, Y2);
    yg = in_rng(ry, Y2, Y3);
    yl = in_rng(ry, Y3, Y4);
    yd = in_rng(ry, Y4, Y5);
    hit_o        = '0;
    hit_o[SEG_A] = xm & ya;
    hit_o[SEG_B] = xr & yu;
    hit_o[SEG_C] = xr & yl;
    hit_o[SEG_D] = xm & yd;
    hit_o[SEG_E] = xl & yl;
    hit_o[SEG_F] = xl & yu;
    hit_o[SEG_G] = xm & yg;
  end

endmodule

// File: rtl/vga_segment_overlay.sv
// Paints the shadowed 7-segment pattern over a VGA stream.
// Ports: i_Clk, i_Reset, vid_i (in video), i_Segments,
// vid_o (out video, 2-cycle latency), o_Locked.
module vga_segment_overlay
  import vga_overlay_pkg::*;
#(
  parameter logic [9:0] H_TOTAL  = H_TOTAL_D,
  parameter logic [9:0] H_BACK   = H_BACK_D,
  parameter logic [9:0] H_ACTIVE = H_ACTIVE_D,
  parameter logic [9:0] V_TOTAL  = V_TOTAL_D,
  parameter logic [9:0] V_BACK   = V_BACK_D,
  parameter logic [9:0] V_ACTIVE = V_ACTIVE_D,
  parameter logic [9:0] ORIGIN_X = ORIGIN_X_D,
  parameter logic [9:0] ORIGIN_Y = ORIGIN_Y_D,
  parameter int         SEG_LEN  = SEG_LEN_D,
  parameter int         SEG_W    = SEG_W_D,
  parameter color_t     FG_RED   = FG_RED_D,
  parameter color_t     FG_GRN   = FG_GRN_D,
  parameter color_t     FG_BLU   = FG_BLU_D
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset,
  vga_segment_overlay_if.slave         vid_i,
  input  logic [6:0]                   i_Segments,
  vga_segment_overlay_if.master        vid_o,
  output logic                         o_Locked
);

  lock_e       state_q, state_d;
  logic        hs1_q, vs1_q;
  color_t      r1_q, g1_q, b1_q;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic        pend_q, pend_d;
  logic [6:0]  seg_q, seg_d;
  logic        hs2_q, vs2_q, lock2_q;
  color_t      r2_q, g2_q, b2_q;
  color_t      r2_d, g2_d, b2_d;

  logic        hs_rise, vs_rise, row0;
  logic        h_act, v_act, fg;
  logic [9:0]  x, y;
  logic signed [10:0] rx, ry;
  logic [6:0]  hit;

  // Stage-1 sync copies double as the edge-detect history
  assign hs_rise = vid_i.hsync & ~hs1_q;
  assign vs_rise = vid_i.vsync & ~vs1_q;
  assign row0    = hs_rise & (pend_q | vs_rise);

  // Counters saturate; a LOCKED frame never reaches the cap
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pend_d = pend_q;
    seg_d  = seg_q;
    if (hs_rise)
      col_d = '0;
    else if (col_q != H_TOTAL)
      col_d = col_q + 10'd1;
    if (vs_rise) begin
      pend_d = 1'b1;
      seg_d  = i_Segments;
    end
    if (row0) begin
      row_d  = '0;
      pend_d = 1'b0;
    end else if (hs_rise && row_q != V_TOTAL) begin
      row_d = row_q + 10'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED:
        if (row0) state_d = LOCKED;
      LOCKED:
        if (col_q == H_TOTAL || row_q == V_TOTAL)
          state_d = UNLOCKED;
      default:
        state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state_q <= UNLOCKED;
    else         state_q <= state_d;
  end

  // Stage 1: col_q/row_q describe the pixel held in r1/g1/b1
  always_comb begin
    h_act = (col_q >= H_BACK) &&
            (col_q < H_BACK + H_ACTIVE);
    v_act = (row_q >= V_BACK) &&
            (row_q < V_BACK + V_ACTIVE);
    x  = col_q - H_BACK;
    y  = row_q - V_BACK;
    rx = $signed({1'b0, x}) - $signed({1'b0, ORIGIN_X});
    ry = $signed({1'b0, y}) - $signed({1'b0, ORIGIN_Y});
  end

  glyph_segment_hit #(
    .SEG_LEN (SEG_LEN),
    .SEG_W   (SEG_W)
  ) u_hit (
    .rx_i  (rx),
    .ry_i  (ry),
    .hit_o (hit)
  );

  always_comb begin
    fg   = (state_q == LOCKED) & h_act & v_act &
           (|(hit & seg_q));
    r2_d = fg ? FG_RED : r1_q;
    g2_d = fg ? FG_GRN : g1_q;
    b2_d = fg ? FG_BLU : b1_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pend_q  <= 1'b0;
      seg_q   <= '0;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      lock2_q <= 1'b0;
      r2_q    <= '0;
      g2_q    <= '0;
      b2_q    <= '0;
    end else begin
      hs1_q   <= vid_i.hsync;
      vs1_q   <= vid_i.vsync;
      r1_q    <= vid_i.red;
      g1_q    <= vid_i.grn;
      b1_q    <= vid_i.blu;
      col_q   <= col_d;
      row_q   <= row_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      lock2_q <= (state_q == LOCKED);
      r2_q    <= r2_d;
      g2_q    <= g2_d;
      b2_q    <= b2_d;
    end
  end

  assign vid_o.hsync = hs2_q;
  assign vid_o.vsync = vs2_q;
  assign vid_o.red   = r2_q;
  assign vid_o.grn   = g2_q;
  assign vid_o.blu   = b2_q;
  assign o_Locked    = lock2_q;

endmodule

// File: tb/tb_vga_segment_overlay.sv
// Directed bench for vga_segment_overlay using a shrunken
// 64x40 raster so whole frames stay short.
module tb_vga_segment_overlay;
  import vga_overlay_pkg::*;

  localparam logic [8:0] FG = 9'o700;
  localparam logic [8:0] BG = 9'o333;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] segs;
  logic       locked;

  always #5 clk = ~clk;

  vga_segment_overlay_if vin();
  vga_segment_overlay_if vout();

  vga_segment_overlay #(
    .H_TOTAL  (10'd64),
    .H_BACK   (10'd6),
    .H_ACTIVE (10'd48),
    .V_TOTAL  (10'd40),
    .V_BACK   (10'd3),
    .V_ACTIVE (10'd34),
    .ORIGIN_X (10'd10),
    .ORIGIN_Y (10'd4),
    .SEG_LEN  (8),
    .SEG_W    (2)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .vid_i      (vin),
    .i_Segments (segs),
    .vid_o      (vout),
    .o_Locked   (locked)
  );

  int     tests = 0;
  int     fails = 0;
  int     gc, gr, sup_row;
  color_t bgr, bgg, bgb;
  logic   last_hs, last_vs, prev_hs, prev_vs;
  color_t last_r, prev_r;

  task automatic chk(
    input string      tag,
    input logic [8:0] obs,
    input logic [8:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Apply the raster position (gc,gr), clock once, advance
  task automatic step();
    logic hs_a, vs_a;
    hs_a = (gc < 56) || (gr == sup_row);
    vs_a = (gr < 38);
    vin.hsync = hs_a;
    vin.vsync = vs_a;
    vin.red   = bgr;
    vin.grn   = bgg;
    vin.blu   = bgb;
    @(posedge clk);
    #1;
    prev_hs = last_hs;
    prev_vs = last_vs;
    prev_r  = last_r;
    last_hs = hs_a;
    last_vs = vs_a;
    last_r  = bgr;
    gc++;
    if (gc == 64) begin
      gc = 0;
      gr++;
      if (gr == 40) gr = 0;
    end
  endtask

  task automatic goto(input int c, input int rw);
    int n;
    n = 0;
    while (!(gc == c && gr == rw) && n < 3000) begin
      step();
      n++;
    end
  endtask

  // Output two steps after applying (c,rw) belongs to (c,rw)
  task automatic chk_px(
    input string      tag,
    input int         c,
    input int         rw,
    input logic [8:0] exp
  );
    goto(c, rw);
    step();
    step();
    chk(tag, {vout.red, vout.grn, vout.blu}, exp);
  endtask

  initial begin
    rst = 1'b1; segs = 7'h7F;
    bgr = 3'd3; bgg = 3'd3; bgb = 3'd3;
    gc = 0; gr = 30; sup_row = -1;
    last_hs = 1'b1; last_vs = 1'b1; last_r = 3'd3;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_r = 3'd3;

    repeat (3) step();
    chk("rst_hs", vout.hsync, 1);
    chk("rst_vs", vout.vsync, 1);
    chk("rst_rgb", {vout.red, vout.grn, vout.blu}, 0);
    chk("rst_lock", locked, 0);
    rst = 1'b0;

    goto(0, 0);
    step();
    chk("pre_lock", locked, 0);
    step();
    chk("lock", locked, 1);

    chk_px("corner_tl", 16, 7, BG);
    chk_px("a_left", 18, 7, FG);
    chk_px("a_right", 24, 7, FG);
    chk_px("corner_tr", 26, 7, BG);
    chk_px("corner_in", 17, 8, BG);
    chk_px("a_mid", 21, 8, FG);
    chk_px("left_out", 15, 9, BG);
    chk_px("gap", 21, 9, BG);
    chk_px("b_top", 26, 9, FG);
    chk_px("f_mid", 16, 12, FG);
    chk_px("g_mid", 21, 17, FG);
    chk_px("e_mid", 17, 20, FG);
    chk_px("c_bot", 27, 26, FG);
    chk_px("d_bot", 21, 28, FG);
    chk_px("below_d", 21, 29, BG);

    goto(0, 30); segs = 7'h06;
    chk_px("one_a", 21, 8, BG);
    chk_px("one_b", 26, 12, FG);
    chk_px("one_g", 21, 17, BG);
    chk_px("one_c", 27, 20, FG);

    goto(0, 30); segs = 7'h40;
    chk_px("gonly_a", 21, 8, BG);
    chk_px("gonly_b", 26, 12, BG);
    chk_px("gonly_g", 21, 17, FG);

    goto(0, 30); segs = 7'h7F;
    chk_px("tear_a0", 21, 8, FG);
    goto(0, 15); segs = 7'h00;
    chk_px("tear_g", 21, 17, FG);
    chk_px("tear_d", 21, 28, FG);
    chk_px("tear_a1", 21, 8, BG);
    chk_px("tear_g1", 21, 17, BG);

    goto(0, 30); segs = 7'h7F;
    chk_px("loss_a0", 21, 8, FG);
    chk_px("loss_e0", 16, 19, FG);
    sup_row = 20;
    chk_px("loss_e1", 16, 21, BG);
    chk("loss_lock", locked, 0);
    sup_row = -1;
    chk_px("relock_a", 21, 8, FG);
    chk("relock", locked, 1);

    goto(0, 5);
    rst = 1'b1;
    repeat (3) step();
    chk("mrst_hs", vout.hsync, 1);
    chk("mrst_vs", vout.vsync, 1);
    chk("mrst_rgb", {vout.red, vout.grn, vout.blu}, 0);
    chk("mrst_lock", locked, 0);
    rst = 1'b0;
    chk_px("mrst_a", 21, 8, BG);
    chk("mrst_nolock", locked, 0);
    chk_px("mrst_a1", 21, 8, FG);
    chk("mrst_relock", locked, 1);

    goto(40, 37);
    for (int i = 0; i < 48; i++) begin
      bgr = (i % 2 == 0) ? 3'd4 : 3'd3;
      step();
      chk("lat_red", vout.red, prev_r);
      chk("lat_hs", vout.hsync, prev_hs);
      chk("lat_vs", vout.vsync, prev_vs);
    end
    bgr = 3'd3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
